// File: rtl/sync_fifo_core_pkg.sv
// Geometry of the queue-manager FIFO instances built on sync_fifo_core.
package sync_fifo_core_pkg;
  localparam int D4K_WIDTH = 8;
  localparam int D4K_DEPTH = 4096;
  localparam int D32_WIDTH = 16;
  localparam int D32_DEPTH = 32;
endpackage

// File: rtl/sfifo_w16_d32.sv
// Queue-manager frame length pointer FIFO: 16-bit words, 32 deep, 1-cycle read latency.
// Upstream throttles from full; overflowing writes are dropped.
module sfifo_w16_d32
  import sync_fifo_core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] din,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty,
  output logic [5:0]  data_count
);

  sync_fifo_core #(
    .WIDTH (D32_WIDTH),
    .DEPTH (D32_DEPTH)
  ) u_core (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count)
  );

endmodule

// File: rtl/sfifo_w8_d4k.sv
// Queue-manager frame data FIFO: 8-bit bytes, 4096 deep, 1-cycle read latency.
// Upstream throttles from data_count; overflowing writes are dropped.
module sfifo_w8_d4k
  import sync_fifo_core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  din,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [12:0] data_count
);

  sync_fifo_core #(
    .WIDTH (D4K_WIDTH),
    .DEPTH (D4K_DEPTH)
  ) u_core (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count)
  );

endmodule

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: port A writes, port B reads synchronously (1-cycle latency).
// No flow control of its own; the read register holds when re is low.
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO, registered dout one cycle after an accepted read, occupancy count.
// Writes when full and reads when empty are dropped; full/empty come from the count.
module sync_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      data_count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign data_count = count;
  assign wr_ok      = wr_en & ~full;
  assign rd_ok      = rd_en & ~empty;

  // Pointers wrap for free since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomized bench for sync_fifo_core (16x32 direct, plus both wrappers) against a queue model.
module tb_sync_fifo_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [15:0] din32, dout32, w_dout;
  logic        wr32, rd32, full32, empty32, w_full, w_empty;
  logic [5:0]  cnt32, w_cnt;

  logic [7:0]  din4k, dout4k;
  logic        wr4k, rd4k, full4k, empty4k;
  logic [12:0] cnt4k;

  sync_fifo_core #(.WIDTH(16), .DEPTH(32)) u_dut (
    .clk(clk), .rstn(rstn), .din(din32), .wr_en(wr32), .rd_en(rd32),
    .dout(dout32), .full(full32), .empty(empty32), .data_count(cnt32));

  sfifo_w16_d32 u_w32 (
    .clk(clk), .rstn(rstn), .din(din32), .wr_en(wr32), .rd_en(rd32),
    .dout(w_dout), .full(w_full), .empty(w_empty), .data_count(w_cnt));

  sfifo_w8_d4k u_d4k (
    .clk(clk), .rstn(rstn), .din(din4k), .wr_en(wr4k), .rd_en(rd4k),
    .dout(dout4k), .full(full4k), .empty(empty4k), .data_count(cnt4k));

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] q32[$];
  logic [7:0]  q4k[$];
  logic [15:0] exp32;
  logic [7:0]  exp4k;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic check32();
    chk("d32_dout",  32'(dout32),  32'(exp32));
    chk("d32_count", 32'(cnt32),   32'(q32.size()));
    chk("d32_full",  32'(full32),  32'(q32.size() == 32));
    chk("d32_empty", 32'(empty32), 32'(q32.size() == 0));
    chk("w32_count", 32'(w_cnt),   32'(q32.size()));
    chk("w32_dout",  32'(w_dout),  32'(exp32));
  endtask

  task automatic check4k();
    chk("d4k_dout",  32'(dout4k),  32'(exp4k));
    chk("d4k_count", 32'(cnt4k),   32'(q4k.size()));
    chk("d4k_full",  32'(full4k),  32'(q4k.size() == 4096));
    chk("d4k_empty", 32'(empty4k), 32'(q4k.size() == 0));
    chk("d4k_bp",    32'(cnt4k > 13'd2578), 32'(q4k.size() >= 2579));
  endtask

  // Model acceptance is decided from the occupancy before the edge.
  task automatic step32(input logic w, input logic r, input logic [15:0] d);
    bit wok, rok;
    wr32 = w; rd32 = r; din32 = d;
    wok = w && (q32.size() < 32);
    rok = r && (q32.size() > 0);
    @(posedge clk);
    if (rok) exp32 = q32.pop_front();
    if (wok) q32.push_back(d);
    #1;
    check32();
  endtask

  task automatic step4k(input logic w, input logic r, input logic [7:0] d);
    bit wok, rok;
    wr4k = w; rd4k = r; din4k = d;
    wok = w && (q4k.size() < 4096);
    rok = r && (q4k.size() > 0);
    @(posedge clk);
    if (rok) exp4k = q4k.pop_front();
    if (wok) q4k.push_back(d);
    #1;
    check4k();
  endtask

  // Asynchronous assertion: outputs are checked before any clock edge arrives.
  task automatic do_reset();
    rstn = 1'b0;
    #2;
    q32.delete(); q4k.delete();
    exp32 = '0; exp4k = '0;
    check32();
    check4k();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int written;
    bit up;
    rstn = 1'b1;
    wr32 = 0; rd32 = 0; din32 = '0;
    wr4k = 0; rd4k = 0; din4k = '0;
    #1;
    do_reset();

    // Reset mid-run discards contents, a following read is ignored
    for (int i = 0; i < 5; i++) step32(1, 0, 16'($urandom));
    do_reset();
    step32(0, 1, 16'h0);

    // Basic order
    step32(1, 0, 16'h0040);
    step32(1, 0, 16'h05EE);
    step32(1, 0, 16'h003C);
    for (int i = 0; i < 3; i++) step32(0, 1, 16'h0);

    // Fill, overflow, then read+write while full drops the write
    for (int i = 0; i < 32; i++) step32(1, 0, 16'(i));
    step32(1, 0, 16'hFFFF);
    step32(1, 1, 16'hFFFF);
    while (q32.size() > 0) step32(0, 1, 16'h0);

    // Read+write while empty: write lands, dout unchanged
    step32(1, 1, 16'hA5A5);
    step32(0, 1, 16'h0);

    // Sustained read+write at count 10
    for (int i = 0; i < 10; i++) step32(1, 0, 16'($urandom));
    for (int i = 0; i < 20; i++) step32(1, 1, 16'($urandom));
    while (q32.size() > 0) step32(0, 1, 16'h0);

    // Underflow then a single write/read
    for (int i = 0; i < 4; i++) step32(0, 1, 16'h0);
    step32(1, 0, 16'h1234);
    step32(0, 1, 16'h0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step32(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom));
    while (q32.size() > 0) step32(0, 1, 16'h0);
    wr32 = 0; rd32 = 0;

    // 4k stream oscillating occupancy between ~2050 and ~2950
    written = 0;
    while (q4k.size() < 2000) begin
      step4k(1, 0, 8'($urandom));
      written++;
    end
    up = 1;
    while (written < 10000) begin
      logic w, r;
      if (q4k.size() >= 2950) up = 0;
      else if (q4k.size() <= 2050) up = 1;
      w = up ? 1'b1 : ($urandom_range(3) == 0);
      r = up ? ($urandom_range(3) == 0) : 1'b1;
      step4k(w, r, 8'($urandom));
      if (w) written++;
    end
    while (q4k.size() > 0) step4k(0, 1, 8'h0);
    wr4k = 0; rd4k = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
